relobi_mux: RTL and testbench
=============================

Name: relobi_mux

Overview:
- Reliable-OBI N:1 multiplexer. Merges NumSbrPorts subordinate-side requesters onto one manager port.
- Complement of the reliable 1:N demux; sits in front of a shared reliable OBI subordinate such as an SRAM or peripheral bus.
- Arbitration and response routing are triplicated per TMR lane, and the state registers are majority-voted every cycle.
- Responses are returned in order through a triplicated source-index FIFO.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig: shared OBI configuration. Integrity=1 is unsupported and triggers $fatal.
- obi_req_t, logic: reliable OBI request struct, with req as [2:0] and rready as [2:0].
- obi_rsp_t, logic: reliable OBI response struct, with gnt and rvalid as [2:0].
- obi_r_chan_t, logic: reliable r channel struct.
- obi_r_optional_t, logic: r optional struct.
- NumSbrPorts, 2: number of requesters, minimum 2.
- NumMaxTrans, 2: maximum outstanding transactions, equal to FIFO depth, minimum 1.
- IdxWidth, cf_math_pkg::idx_width(NumSbrPorts): width of a source index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- sbr_ports_req_i  in  [NumSbrPorts] obi_req_t  requests from requesters.
- sbr_ports_rsp_o  out  [NumSbrPorts] obi_rsp_t  responses to requesters.
- mgr_port_req_o  out  obi_req_t  merged request.
- mgr_port_rsp_i  in  obi_rsp_t  response from shared subordinate.
- fault_o  out  2  [0] = any voter or protocol fault this cycle; [1] = reserved, tied 0.

Behaviour:
- Reset (rst_i high, asynchronous):
  - All lane state clears: rr_ptr=0, lock=0, wptr=rptr=0, count=0.
  - All outputs are 0 while reset is held.
  - Reset mid-transaction drops all outstanding routing information; the bench must not expect in-flight responses to be delivered.
- Per-lane arbitration, lane i in 0..2, combinational, zero latency:
  - Candidates: ports p with sbr_ports_req_i[p].req[i]=1.
  - If lock[i]=1, the choice is locked_idx[i], so an issued-but-ungranted request stays on the bus (OBI stability rule).
  - Otherwise the choice is the first requesting port at or above rr_ptr[i], wrapping at NumSbrPorts.
  - mgr_port_req_o.req[i]=1 iff a candidate exists and count[i] < NumMaxTrans.
  - sbr_ports_rsp_o[sel_i].gnt[i] = mgr_port_rsp_i.gnt[i]. All other ports' gnt[i]=0.
- Address phase:
  - mgr_port_req_o.a is taken from the port whose index is the bitwise majority of sel_0, sel_1, sel_2.
  - A disagreement among the three selections sets fault_o[0].
- Handshake on lane i (req[i] & gnt[i]):
  - Push sel_i into FIFO lane i.
  - rr_ptr[i] := sel_i+1, wrapping to 0 after NumSbrPorts-1.
  - lock[i] := 0.
- Request without grant: lock[i] := 1, locked_idx[i] := sel_i.
- FIFO full (count[i]==NumMaxTrans): req[i] is held low, so no grant can reach any requester on that lane.
- Response routing, lane i:
  - Head index h_i = fifo[i][rptr[i]].
  - sbr_ports_rsp_o[h_i].rvalid[i] = mgr_port_rsp_i.rvalid[i]. All other ports see rvalid[i]=0.
  - r fields are broadcast to every port unchanged (already TMR/ECC-protected at the source).
  - With ObiCfg.UseRReady: mgr_port_req_o.rready[i] = sbr_ports_req_i[h_i].rready[i]. Otherwise pop_i = rvalid[i].
  - On pop: rptr[i] increments, wrapping at NumMaxTrans.
- Boundary cases:
  - Simultaneous push and pop on a lane: count unchanged, both pointers advance.
  - rvalid[i] with count[i]==0: the response is dropped to all ports, fault_o[0]=1, state unchanged.
- TMR voting:
  - Next-state values of rr_ptr, lock, locked_idx, wptr, rptr and count are formed independently per lane.
  - Each is voted by bitwise_TMR_voter_fail into all three lane registers, so a single upset is corrected within 1 cycle.
  - Any voter mismatch sets fault_o[0] in that cycle.
  - FIFO storage entries are written per lane and voted on read.
- Latency: request path 0 cycles, response path 0 cycles, state update 1 cycle.

Test Plan:
- Ports 0 and 1 request every cycle, gnt=3'b111, rvalid returned 1 cycle later -> grants alternate 0,1,0,1; responses reach port 0 then 1; fault_o=0.
- NumMaxTrans=2, port 2 requests, gnt always 1, rvalid held 0 -> 2 grants, then mgr req=3'b000. One rvalid=3'b111 -> 1 further grant.
- Port 1 requests with gnt=0 for 3 cycles while port 0 raises req in cycle 2 -> mgr a stays port 1's address; port 1 is granted first.
- UseRReady=1, head=port 0 with rready=0, rvalid=1 -> port 0 sees rvalid=3'b111 and no pop; rready=1 -> pop, count 1->0.
- Force rr_ptr lane 1 to a wrong value -> corrected next cycle, fault_o[0]=1 for 1 cycle, grant order unchanged.
- rvalid=3'b111 with empty FIFO -> no port rvalid, fault_o[0]=1. Assert rst_i mid-burst -> all outputs 0 immediately, count=0.

Source files
------------

// File: rtl/relobi_mux.sv
// Reliable-OBI N:1 multiplexer. Three independent lanes arbitrate and route
// responses; all lane state is majority-voted back into every lane each cycle.
module relobi_mux #(
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned NumMaxTrans = 2,
  parameter int unsigned AChanWidth  = 32,
  parameter int unsigned RChanWidth  = 32,
  parameter bit          UseRReady   = 1'b0,
  parameter bit          Integrity   = 1'b0,
  parameter int unsigned IdxWidth    = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1,
  parameter int unsigned ReqWidth    = AChanWidth + 6,
  parameter int unsigned RspWidth    = RChanWidth + 6
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumSbrPorts-1:0][ReqWidth-1:0] sbr_ports_req_i,
  output logic [NumSbrPorts-1:0][RspWidth-1:0] sbr_ports_rsp_o,
  output logic [ReqWidth-1:0]                  mgr_port_req_o,
  input  logic [RspWidth-1:0]                  mgr_port_rsp_i,
  output logic [1:0]                           fault_o
);
  // Request word: [2:0] req, [5:3] rready, [ReqWidth-1:6] a channel.
  // Response word: [2:0] gnt, [5:3] rvalid, [RspWidth-1:6] r channel.
  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
  localparam int unsigned StWidth  = 2 * IdxWidth + 1 + 2 * PtrWidth + CntWidth;

  if (Integrity) begin : gen_integrity_unsupported
    $fatal(1, "relobi_mux: Integrity=1 is not supported");
  end
  if (NumSbrPorts < 2 || NumMaxTrans < 1) begin : gen_bad_params
    $fatal(1, "relobi_mux: needs NumSbrPorts >= 2 and NumMaxTrans >= 1");
  end

  logic [2:0]                gnt_in, rvalid_in;
  logic [2:0]                lane_req, lane_hs, lane_rready, rvalid_ok, nonempty;
  logic [2:0][IdxWidth-1:0]  sel, head;
  logic [2:0][PtrWidth-1:0]  wptr, rptr;
  logic [2:0][StWidth-1:0]   st_d;
  logic [2:0]                head_flt;
  logic [StWidth-1:0]        st_voted;
  logic [IdxWidth-1:0]       sel_maj;
  logic                      st_flt, sel_flt;
  logic [IdxWidth-1:0]       fifo_q [3][NumMaxTrans];

  assign gnt_in    = mgr_port_rsp_i[2:0];
  assign rvalid_in = mgr_port_rsp_i[5:3];

  for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d, locked_idx_q, locked_idx_d;
    logic [IdxWidth-1:0] rr_pick, lane_sel;
    logic                lock_q, lock_d, rr_found, lock_hold, full;
    logic                head_rready, lane_pop;
    logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
      rr_pick     = rr_ptr_q;
      rr_found    = 1'b0;
      lock_hold   = 1'b0;
      head_rready = 1'b0;
      // First pass: ports at or above the pointer; second pass wraps around.
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (!rr_found && p >= int'(rr_ptr_q) && sbr_ports_req_i[p][gi]) begin
          rr_found = 1'b1;
          rr_pick  = IdxWidth'(p);
        end
      end
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (!rr_found && sbr_ports_req_i[p][gi]) begin
          rr_found = 1'b1;
          rr_pick  = IdxWidth'(p);
        end
      end
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (lock_q && locked_idx_q == IdxWidth'(p) && sbr_ports_req_i[p][gi]) lock_hold = 1'b1;
        if (head[gi] == IdxWidth'(p)) head_rready = sbr_ports_req_i[p][3+gi];
      end
    end

    assign lane_sel  = lock_hold ? locked_idx_q : rr_pick;
    assign full      = (count_q == CntWidth'(NumMaxTrans));
    assign lane_req[gi] = (lock_hold | rr_found) & ~full;
    assign lane_hs[gi]  = lane_req[gi] & gnt_in[gi];
    assign nonempty[gi] = (count_q != '0);
    assign rvalid_ok[gi] = rvalid_in[gi] & nonempty[gi];
    assign lane_rready[gi] = UseRReady ? (nonempty[gi] & head_rready) : 1'b1;
    assign lane_pop = rvalid_ok[gi] & lane_rready[gi];

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (lane_hs[gi]) begin
        rr_ptr_d = (lane_sel == IdxWidth'(NumSbrPorts - 1)) ? '0 : lane_sel + IdxWidth'(1);
      end
      lock_d       = lane_req[gi] & ~gnt_in[gi];
      locked_idx_d = lock_d ? lane_sel : locked_idx_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (lane_hs[gi]) wptr_d = (wptr_q == PtrWidth'(NumMaxTrans - 1)) ? '0 : wptr_q + PtrWidth'(1);
      if (lane_pop)    rptr_d = (rptr_q == PtrWidth'(NumMaxTrans - 1)) ? '0 : rptr_q + PtrWidth'(1);
      case ({lane_hs[gi], lane_pop})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end

    assign st_d[gi] = {rr_ptr_d, lock_d, locked_idx_d, wptr_d, rptr_d, count_d};
    assign sel[gi]  = lane_sel;
    assign wptr[gi] = wptr_q;
    assign rptr[gi] = rptr_q;

    // Every lane reloads from the voted value, so a single upset heals in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rr_ptr_q     <= '0;
        lock_q       <= 1'b0;
        locked_idx_q <= '0;
        wptr_q       <= '0;
        rptr_q       <= '0;
        count_q      <= '0;
      end else begin
        {rr_ptr_q, lock_q, locked_idx_q, wptr_q, rptr_q, count_q} <= st_voted;
      end
    end
  end

  assign st_voted = (st_d[0] & st_d[1]) | (st_d[0] & st_d[2]) | (st_d[1] & st_d[2]);
  assign st_flt   = |((st_d[0] ^ st_d[1]) | (st_d[1] ^ st_d[2]));
  assign sel_maj  = (sel[0] & sel[1]) | (sel[0] & sel[2]) | (sel[1] & sel[2]);
  assign sel_flt  = |((sel[0] ^ sel[1]) | (sel[1] ^ sel[2]));

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 3; l++) begin
      if (lane_hs[l]) fifo_q[l][wptr[l]] <= sel[l];
    end
  end

  // Head entry is voted across the three lane copies at this lane's read pointer.
  always_comb begin
    head     = '0;
    head_flt = '0;
    for (int l = 0; l < 3; l++) begin
      head[l] = (fifo_q[0][rptr[l]] & fifo_q[1][rptr[l]]) |
                (fifo_q[0][rptr[l]] & fifo_q[2][rptr[l]]) |
                (fifo_q[1][rptr[l]] & fifo_q[2][rptr[l]]);
      head_flt[l] = nonempty[l] & (|((fifo_q[0][rptr[l]] ^ fifo_q[1][rptr[l]]) |
                                     (fifo_q[1][rptr[l]] ^ fifo_q[2][rptr[l]])));
    end
  end

  always_comb begin
    mgr_port_req_o  = '0;
    sbr_ports_rsp_o = '0;
    fault_o         = '0;
    if (!rst_i) begin
      mgr_port_req_o[2:0] = lane_req;
      mgr_port_req_o[5:3] = lane_rready;
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (sel_maj == IdxWidth'(p)) mgr_port_req_o[ReqWidth-1:6] = sbr_ports_req_i[p][ReqWidth-1:6];
        for (int l = 0; l < 3; l++) begin
          sbr_ports_rsp_o[p][l]   = lane_hs[l] & (sel[l] == IdxWidth'(p));
          sbr_ports_rsp_o[p][3+l] = rvalid_ok[l] & (head[l] == IdxWidth'(p));
        end
        sbr_ports_rsp_o[p][RspWidth-1:6] = mgr_port_rsp_i[RspWidth-1:6];
      end
      // A response with nothing outstanding is dropped and flagged.
      fault_o[0] = st_flt | sel_flt | (|head_flt) | (|(rvalid_in & ~nonempty));
    end
  end

endmodule

// File: tb/tb_relobi_mux.sv
// Directed bench for relobi_mux: 3 requesters, 2 outstanding, rready honoured.
module tb_relobi_mux;
  localparam int NP = 3;
  localparam int NV = 27;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0][13:0]    sbr_req;
  logic [NP-1:0][13:0]    sbr_rsp;
  logic [13:0]            mgr_req;
  logic [13:0]            mgr_rsp;
  logic [1:0]             fault;

  int n_applied     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  relobi_mux #(
    .NumSbrPorts(NP), .NumMaxTrans(2), .AChanWidth(8), .RChanWidth(8),
    .UseRReady(1'b1), .Integrity(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .sbr_ports_req_i(sbr_req), .sbr_ports_rsp_o(sbr_rsp),
    .mgr_port_req_o(mgr_req), .mgr_port_rsp_i(mgr_rsp),
    .fault_o(fault)
  );

  typedef struct {
    logic [2:0] reqp, gnt, rvalid, rrdy;
    logic [2:0] e_req;
    logic       chk_a;
    logic [7:0] e_a;
    logic [2:0] e_gnt, e_rvalid, e_rready;
    logic       e_fault;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] reqp, gnt, rvalid, rrdy, e_req,
                              input logic chk_a, input logic [7:0] e_a,
                              input logic [2:0] e_gnt, e_rvalid, e_rready, input logic e_fault);
    vec_t v;
    v.reqp = reqp; v.gnt = gnt; v.rvalid = rvalid; v.rrdy = rrdy; v.e_req = e_req;
    v.chk_a = chk_a; v.e_a = e_a; v.e_gnt = e_gnt; v.e_rvalid = e_rvalid;
    v.e_rready = e_rready; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic drive(input logic [2:0] reqp, gnt, rvalid, rrdy);
    for (int p = 0; p < NP; p++) begin
      sbr_req[p] = {8'(8'hA0 + p), rrdy[p] ? 3'b111 : 3'b000, reqp[p] ? 3'b111 : 3'b000};
    end
    mgr_rsp = {8'h5C, rvalid, gnt};
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input int i);
    vec_t v;
    v = vecs[i];
    check($sformatf("v%0d mgr_req", i), 16'(mgr_req[2:0]), 16'(v.e_req));
    check($sformatf("v%0d mgr_rready", i), 16'(mgr_req[5:3]), 16'(v.e_rready));
    if (v.chk_a) check($sformatf("v%0d mgr_a", i), 16'(mgr_req[13:6]), 16'(v.e_a));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("v%0d gnt[%0d]", i, p), 16'(sbr_rsp[p][2:0]), v.e_gnt[p] ? 16'h7 : 16'h0);
      check($sformatf("v%0d rvalid[%0d]", i, p), 16'(sbr_rsp[p][5:3]), v.e_rvalid[p] ? 16'h7 : 16'h0);
      check($sformatf("v%0d r[%0d]", i, p), 16'(sbr_rsp[p][13:6]), 16'h5C);
    end
    check($sformatf("v%0d fault", i), 16'(fault), 16'({1'b0, v.e_fault}));
    $display("vec %0d: req=%b a=%h gnt=%h,%h,%h fault=%b", i, mgr_req[2:0], mgr_req[13:6],
             sbr_rsp[0][2:0], sbr_rsp[1][2:0], sbr_rsp[2][2:0], fault);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(vecs[i].reqp, vecs[i].gnt, vecs[i].rvalid, vecs[i].rrdy);
      #1;
      check_vec(i);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " mgr_req"}, 16'(mgr_req), 16'h0);
    for (int p = 0; p < NP; p++) check($sformatf("%s rsp[%0d]", nm, p), 16'(sbr_rsp[p]), 16'h0);
    check({nm, " fault"}, 16'(fault), 16'h0);
  endtask

  initial begin
    //              reqp    gnt     rvalid  rrdy    e_req  a  e_a    e_gnt   e_rval  e_rrdy  flt
    // Ports 0/1 alternate, responses follow one cycle later, then empty-rvalid drop.
    vecs[0]  = mk(3'b011, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA0, 3'b001, 3'b000, 3'b000, 0);
    vecs[1]  = mk(3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 1, 8'hA1, 3'b010, 3'b001, 3'b111, 0);
    vecs[2]  = mk(3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 1, 8'hA0, 3'b001, 3'b010, 3'b111, 0);
    vecs[3]  = mk(3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b001, 3'b111, 0);
    vecs[4]  = mk(3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b000, 3'b000, 0);
    vecs[5]  = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b000, 3'b000, 1);
    // Port 2 fills the FIFO; req drops while full, one pop buys one more grant.
    vecs[6]  = mk(3'b100, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA2, 3'b100, 3'b000, 3'b000, 0);
    vecs[7]  = mk(3'b100, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA2, 3'b100, 3'b000, 3'b111, 0);
    vecs[8]  = mk(3'b100, 3'b111, 3'b000, 3'b111, 3'b000, 1, 8'hA2, 3'b000, 3'b000, 3'b111, 0);
    vecs[9]  = mk(3'b100, 3'b111, 3'b111, 3'b111, 3'b000, 1, 8'hA2, 3'b000, 3'b100, 3'b111, 0);
    vecs[10] = mk(3'b100, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA2, 3'b100, 3'b000, 3'b111, 0);
    vecs[11] = mk(3'b100, 3'b111, 3'b000, 3'b111, 3'b000, 1, 8'hA2, 3'b000, 3'b000, 3'b111, 0);
    vecs[12] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b100, 3'b111, 0);
    vecs[13] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b100, 3'b111, 0);
    // Port 1 stalls without grant; port 0 joins but must wait.
    vecs[14] = mk(3'b010, 3'b000, 3'b000, 3'b111, 3'b111, 1, 8'hA1, 3'b000, 3'b000, 3'b000, 0);
    vecs[15] = mk(3'b011, 3'b000, 3'b000, 3'b111, 3'b111, 1, 8'hA1, 3'b000, 3'b000, 3'b000, 0);
    vecs[16] = mk(3'b011, 3'b000, 3'b000, 3'b111, 3'b111, 1, 8'hA1, 3'b000, 3'b000, 3'b000, 0);
    vecs[17] = mk(3'b011, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA1, 3'b010, 3'b000, 3'b000, 0);
    vecs[18] = mk(3'b001, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA0, 3'b001, 3'b000, 3'b111, 0);
    vecs[19] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b010, 3'b111, 0);
    vecs[20] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b001, 3'b111, 0);
    // rready back-pressure from the head requester holds the entry.
    vecs[21] = mk(3'b001, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA0, 3'b001, 3'b000, 3'b000, 0);
    vecs[22] = mk(3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 0, 8'h00, 3'b000, 3'b001, 3'b000, 0);
    vecs[23] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b001, 3'b111, 0);
    vecs[24] = mk(3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 0, 8'h00, 3'b000, 3'b000, 3'b000, 1);
    // Grant order after the injected upset is healed.
    vecs[25] = mk(3'b011, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA1, 3'b010, 3'b000, 3'b000, 0);
    vecs[26] = mk(3'b011, 3'b111, 3'b000, 3'b111, 3'b111, 1, 8'hA0, 3'b001, 3'b000, 3'b111, 0);

    rst = 1'b1;
    drive(3'b011, 3'b111, 3'b111, 3'b111);
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 3'b111);

    apply_range(0, 24);

    // Single-lane upset of the round-robin pointer while idle.
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 3'b111);
    force dut.gen_lane[1].rr_ptr_q = 2'd2;
    #1 check("upset_fault", 16'(fault), 16'h1);
    release dut.gen_lane[1].rr_ptr_q;
    @(negedge clk);
    #1 check("upset_healed", 16'(fault), 16'h0);

    apply_range(25, 26);

    // Reset with two transactions outstanding drops all routing state.
    @(negedge clk);
    drive(3'b011, 3'b111, 3'b111, 3'b111);
    rst = 1'b1;
    #1 check_all_zero("reset_mid_burst");
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 3'b000, 3'b111, 3'b111);
    #1;
    check("post_reset_fault", 16'(fault), 16'h1);
    check("post_reset_req", 16'(mgr_req[2:0]), 16'h0);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("post_reset_rvalid[%0d]", p), 16'(sbr_rsp[p][5:3]), 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
